multicycle_sequencer: RTL and testbench

- Parametrised successor to the monolithic control FSM: owns only the instruction-independent sequencing of the multicycle CPU.
- That sequencing covers:
  - fetch with configurable memory wait
  - decode/dispatch
  - an execute-step counter that drives per-instruction microcode
  - mult/div handshake with timeout
  - vectored exception entry (EPC save, vector byte load)
  - halt on break
- Per-instruction datapath selects are generated externally from step and state.

---
 rtl/multicycle_sequencer_if.sv | 49 ++++
 rtl/multicycle_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_sequencer_if.sv
// Control bundle between the multicycle sequencer and the datapath.
// master: sequencer side (decoder flags in, control strobes out).
// slave:  datapath side (drives decoder flags, consumes strobes).
interface multicycle_sequencer_if #(
    parameter int STEP_W = 3
);
    logic              invalid_opcode;
    logic              is_break;
    logic [STEP_W-1:0] exec_steps;
    logic              is_muldiv;
    logic              ovf_check;
    logic              overflow;
    logic              divzero;
    logic              md_done;

    logic [3:0]        state;
    logic [STEP_W-1:0] step;
    logic              pc_write;
    logic              ir_write;
    logic              ab_write;
    logic              epc_write;
    logic              md_start;
    logic              exc_load;
    logic [2:0]        IorD;
    logic [7:0]        exc_addr;
    logic [1:0]        exc_code;
    logic              reset_out;
    logic              halted;

    modport master (
        input  invalid_opcode, is_break, exec_steps,
        input  is_muldiv, ovf_check, overflow,
        input  divzero, md_done,
        output state, step, pc_write, ir_write,
        output ab_write, epc_write, md_start,
        output exc_load, IorD, exc_addr, exc_code,
        output reset_out, halted
    );

    modport slave (
        output invalid_opcode, is_break, exec_steps,
        output is_muldiv, ovf_check, overflow,
        output divzero, md_done,
        input  state, step, pc_write, ir_write,
        input  ab_write, epc_write, md_start,
        input  exc_load, IorD, exc_addr, exc_code,
        input  reset_out, halted
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// Instruction-independent sequencer of the multicycle CPU: fetch wait,
// decode/dispatch, execute-step counter, mult/div wait, exceptions, halt.
// Ports: clk, reset (sync, active-high), bus (master modport; all flags
// and registered control outputs are in multicycle_sequencer_if).
module multicycle_sequencer #(
    parameter int          MEM_WAIT   = 2,
    parameter int          STEP_W     = 3,
    parameter int          MD_TIMEOUT = 40,
    parameter int          TMR_W      = 6,
    parameter logic [7:0]  EXC_BASE   = 8'd253
) (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        S_RESET   = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_EXEC    = 4'd3,
        S_MD_WAIT = 4'd4,
        S_EXC_EPC = 4'd5,
        S_EXC_RD  = 4'd6,
        S_EXC_LD  = 4'd7,
        S_HALT    = 4'd8
    } state_t;

    localparam logic [TMR_W-1:0] MW     = TMR_W'(MEM_WAIT);
    localparam logic [TMR_W-1:0] MW_M1  = TMR_W'(MEM_WAIT - 1);
    localparam logic [TMR_W-1:0] MD_END = TMR_W'(MD_TIMEOUT - 1);

    state_t            state_q;
    logic [TMR_W-1:0]  tmr_q;
    logic [STEP_W-1:0] step_q;
    logic [STEP_W-1:0] steps_q;
    logic              md_q;
    logic              ovf_q;
    logic              pc_write_q;
    logic              ir_write_q;
    logic              ab_write_q;
    logic              epc_write_q;
    logic              md_start_q;
    logic              exc_load_q;
    logic [2:0]        iord_q;
    logic [7:0]        exc_addr_q;
    logic [1:0]        exc_code_q;
    logic              reset_out_q;
    logic              halted_q;

    logic [STEP_W-1:0] step_d;
    logic [TMR_W-1:0]  tmr_d;
    logic              last_d;
    logic [7:0]        vec_d;

    assign step_d = step_q + STEP_W'(1);
    assign tmr_d  = tmr_q + TMR_W'(1);
    assign last_d = (step_q == steps_q - STEP_W'(1));
    // Codes 2 and 3 share the last vector byte.
    assign vec_d  = EXC_BASE + ((exc_code_q == 2'd3) ?
                                8'd2 : {6'd0, exc_code_q});

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_RESET;
            tmr_q       <= '0;
            step_q      <= '0;
            steps_q     <= '0;
            md_q        <= 1'b0;
            ovf_q       <= 1'b0;
            pc_write_q  <= 1'b0;
            ir_write_q  <= 1'b0;
            ab_write_q  <= 1'b0;
            epc_write_q <= 1'b0;
            md_start_q  <= 1'b0;
            exc_load_q  <= 1'b0;
            iord_q      <= 3'b000;
            exc_addr_q  <= 8'd0;
            exc_code_q  <= 2'd0;
            reset_out_q <= 1'b1;
            halted_q    <= 1'b0;
        end else begin
            // Strobes are one-cycle unless re-asserted below.
            pc_write_q  <= 1'b0;
            ir_write_q  <= 1'b0;
            ab_write_q  <= 1'b0;
            epc_write_q <= 1'b0;
            md_start_q  <= 1'b0;
            exc_load_q  <= 1'b0;
            iord_q      <= 3'b000;
            reset_out_q <= 1'b0;
            halted_q    <= 1'b0;
            unique case (state_q)
                S_RESET: begin
                    state_q <= S_FETCH;
                    tmr_q   <= '0;
                end
                S_FETCH: begin
                    if (tmr_q == MW) begin
                        state_q    <= S_DECODE;
                        ab_write_q <= 1'b1;
                    end else begin
                        tmr_q <= tmr_d;
                        if (tmr_q == MW_M1) begin
                            pc_write_q <= 1'b1;
                            ir_write_q <= 1'b1;
                        end
                    end
                end
                S_DECODE: begin
                    if (bus.invalid_opcode) begin
                        state_q     <= S_EXC_EPC;
                        epc_write_q <= 1'b1;
                        exc_code_q  <= 2'd0;
                    end else if (bus.is_break) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end else if (bus.exec_steps == '0) begin
                        state_q <= S_FETCH;
                        tmr_q   <= '0;
                    end else begin
                        state_q <= S_EXEC;
                        steps_q <= bus.exec_steps;
                        md_q    <= bus.is_muldiv;
                        ovf_q   <= bus.ovf_check;
                        step_q  <= '0;
                    end
                end
                S_EXEC: begin
                    if (step_q == '0 && md_q) begin
                        if (bus.divzero) begin
                            state_q     <= S_EXC_EPC;
                            epc_write_q <= 1'b1;
                            exc_code_q  <= 2'd2;
                        end else begin
                            state_q    <= S_MD_WAIT;
                            md_start_q <= 1'b1;
                            tmr_q      <= '0;
                        end
                    end else if (last_d) begin
                        if (ovf_q && bus.overflow) begin
                            state_q     <= S_EXC_EPC;
                            epc_write_q <= 1'b1;
                            exc_code_q  <= 2'd1;
                        end else begin
                            state_q <= S_FETCH;
                            step_q  <= '0;
                            tmr_q   <= '0;
                        end
                    end else begin
                        step_q <= step_d;
                    end
                end
                S_MD_WAIT: begin
                    // Completion beats a timeout in the same cycle.
                    if (bus.md_done) begin
                        if (last_d) begin
                            state_q <= S_FETCH;
                            step_q  <= '0;
                            tmr_q   <= '0;
                        end else begin
                            state_q <= S_EXEC;
                            step_q  <= step_d;
                        end
                    end else if (tmr_q == MD_END) begin
                        state_q     <= S_EXC_EPC;
                        epc_write_q <= 1'b1;
                        exc_code_q  <= 2'd3;
                    end else begin
                        tmr_q <= tmr_d;
                    end
                end
                S_EXC_EPC: begin
                    state_q    <= S_EXC_RD;
                    tmr_q      <= '0;
                    iord_q     <= 3'b010;
                    exc_addr_q <= vec_d;
                end
                S_EXC_RD: begin
                    if (tmr_q == MW_M1) begin
                        state_q    <= S_EXC_LD;
                        exc_load_q <= 1'b1;
                    end else begin
                        tmr_q  <= tmr_d;
                        iord_q <= 3'b010;
                    end
                end
                S_EXC_LD: begin
                    state_q <= S_FETCH;
                    tmr_q   <= '0;
                end
                S_HALT: begin
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q     <= S_RESET;
                    reset_out_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.state     = state_q;
    assign bus.step      = step_q;
    assign bus.pc_write  = pc_write_q;
    assign bus.ir_write  = ir_write_q;
    assign bus.ab_write  = ab_write_q;
    assign bus.epc_write = epc_write_q;
    assign bus.md_start  = md_start_q;
    assign bus.exc_load  = exc_load_q;
    assign bus.IorD      = iord_q;
    assign bus.exc_addr  = exc_addr_q;
    assign bus.exc_code  = exc_code_q;
    assign bus.reset_out = reset_out_q;
    assign bus.halted    = halted_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer (MEM_WAIT=2, MD_TIMEOUT=40).
// Outputs are sampled 1 time unit after each rising edge.
module tb_multicycle_sequencer;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    multicycle_sequencer_if #(.STEP_W(3)) bus ();

    multicycle_sequencer #(
        .MEM_WAIT   (2),
        .STEP_W     (3),
        .MD_TIMEOUT (40),
        .TMR_W      (6),
        .EXC_BASE   (8'd253)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.invalid_opcode = 1'b0;
        bus.is_break       = 1'b0;
        bus.exec_steps     = 3'd0;
        bus.is_muldiv      = 1'b0;
        bus.ovf_check      = 1'b0;
        bus.overflow       = 1'b0;
        bus.divzero        = 1'b0;
        bus.md_done        = 1'b0;
    endtask

    // From the first FETCH cycle to the DECODE cycle.
    task automatic to_decode();
        tick();
        tick();
        tick();
    endtask

    function automatic logic [5:0] wen();
        return {bus.pc_write, bus.ir_write, bus.ab_write,
                bus.epc_write, bus.md_start, bus.exc_load};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        tick();
        tests++;
        if (bus.state !== 4'd0 || bus.reset_out !== 1'b1) begin
            fails++;
            $display("FAIL rst_hold state=%0d rout=%0b exp 0/1",
                     bus.state, bus.reset_out);
        end
        tests++;
        if (wen() !== 6'b0 || bus.exc_code !== 2'd0 ||
            bus.step !== 3'd0 || bus.halted !== 1'b0) begin
            fails++;
            $display("FAIL rst_outs wen=%b code=%0d step=%0d exp 0",
                     wen(), bus.exc_code, bus.step);
        end
        reset = 1'b0;
        tick();
        tests++;
        if (bus.state !== 4'd1 || bus.reset_out !== 1'b0 ||
            bus.pc_write !== 1'b0) begin
            fails++;
            $display("FAIL rst_fetch1 state=%0d rout=%0b pcw=%0b",
                     bus.state, bus.reset_out, bus.pc_write);
        end
        tick();
        tests++;
        if (bus.pc_write !== 1'b0 || bus.IorD !== 3'b000) begin
            fails++;
            $display("FAIL rst_fetch2 pcw=%0b iord=%b exp 0/000",
                     bus.pc_write, bus.IorD);
        end
        tick();
        tests++;
        if ({bus.pc_write, bus.ir_write} !== 2'b11 ||
            bus.state !== 4'd1) begin
            fails++;
            $display("FAIL rst_fetch3 pcw/irw=%b%b state=%0d exp 11/1",
                     bus.pc_write, bus.ir_write, bus.state);
        end
        tick();
        tests++;
        if (bus.state !== 4'd2 || wen() !== 6'b001000) begin
            fails++;
            $display("FAIL rst_decode state=%0d wen=%b exp 2/001000",
                     bus.state, wen());
        end
        bus.exec_steps = 3'd0;
        tick();
        tests++;
        if (bus.state !== 4'd1 || bus.step !== 3'd0) begin
            fails++;
            $display("FAIL nop_fetch state=%0d step=%0d exp 1/0",
                     bus.state, bus.step);
        end
    endtask

    task automatic test_alu();
        to_decode();
        bus.exec_steps = 3'd2;
        bus.ovf_check  = 1'b1;
        tick();
        clear_in();
        tests++;
        if (bus.state !== 4'd3 || bus.step !== 3'd0) begin
            fails++;
            $display("FAIL alu_s0 state=%0d step=%0d exp 3/0",
                     bus.state, bus.step);
        end
        tick();
        tests++;
        if (bus.state !== 4'd3 || bus.step !== 3'd1) begin
            fails++;
            $display("FAIL alu_s1 state=%0d step=%0d exp 3/1",
                     bus.state, bus.step);
        end
        tick();
        tests++;
        if (bus.state !== 4'd1 || bus.step !== 3'd0 ||
            bus.epc_write !== 1'b0) begin
            fails++;
            $display("FAIL alu_ret state=%0d step=%0d exp 1/0",
                     bus.state, bus.step);
        end
    endtask

    task automatic test_max_steps();
        to_decode();
        bus.exec_steps = 3'd7;
        tick();
        clear_in();
        // Ignored: no ovf_check, not a muldiv instruction.
        bus.overflow = 1'b1;
        bus.divzero  = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tests++;
            if (bus.state !== 4'd3 || bus.step !== 3'(i)) begin
                fails++;
                $display("FAIL max_step state=%0d step=%0d exp 3/%0d",
                         bus.state, bus.step, i);
            end
            tick();
        end
        clear_in();
        tests++;
        if (bus.state !== 4'd1 || bus.step !== 3'd0) begin
            fails++;
            $display("FAIL max_ret state=%0d step=%0d exp 1/0",
                     bus.state, bus.step);
        end
    endtask

    task automatic test_overflow();
        to_decode();
        bus.exec_steps = 3'd1;
        bus.ovf_check  = 1'b1;
        tick();
        clear_in();
        bus.overflow = 1'b1;
        tick();
        bus.overflow = 1'b0;
        tests++;
        if (bus.state !== 4'd5 || bus.epc_write !== 1'b1 ||
            bus.exc_code !== 2'd1) begin
            fails++;
            $display("FAIL ovf_epc state=%0d epcw=%0b code=%0d exp 5/1/1",
                     bus.state, bus.epc_write, bus.exc_code);
        end
        tick();
        tests++;
        if (bus.state !== 4'd6 || bus.IorD !== 3'b010 ||
            bus.exc_addr !== 8'd254 || bus.epc_write !== 1'b0) begin
            fails++;
            $display("FAIL ovf_rd1 state=%0d iord=%b addr=%0d exp 6/010/254",
                     bus.state, bus.IorD, bus.exc_addr);
        end
        tick();
        tests++;
        if (bus.state !== 4'd6 || bus.IorD !== 3'b010 ||
            bus.exc_addr !== 8'd254) begin
            fails++;
            $display("FAIL ovf_rd2 state=%0d iord=%b addr=%0d exp 6/010/254",
                     bus.state, bus.IorD, bus.exc_addr);
        end
        tick();
        tests++;
        if (bus.state !== 4'd7 || bus.exc_load !== 1'b1 ||
            bus.IorD !== 3'b000) begin
            fails++;
            $display("FAIL ovf_ld state=%0d exl=%0b iord=%b exp 7/1/000",
                     bus.state, bus.exc_load, bus.IorD);
        end
        tick();
        tests++;
        if (bus.state !== 4'd1 || bus.exc_code !== 2'd1 ||
            bus.exc_load !== 1'b0) begin
            fails++;
            $display("FAIL ovf_ret state=%0d code=%0d exp 1/1",
                     bus.state, bus.exc_code);
        end
    endtask

    task automatic test_muldiv();
        int starts;
        to_decode();
        bus.is_muldiv  = 1'b1;
        bus.exec_steps = 3'd2;
        tick();
        clear_in();
        tests++;
        if (bus.state !== 4'd3 || bus.md_start !== 1'b0) begin
            fails++;
            $display("FAIL md_exec state=%0d mds=%0b exp 3/0",
                     bus.state, bus.md_start);
        end
        tick();
        tests++;
        if (bus.state !== 4'd4 || bus.md_start !== 1'b1) begin
            fails++;
            $display("FAIL md_start state=%0d mds=%0b exp 4/1",
                     bus.state, bus.md_start);
        end
        starts = 1;
        for (int i = 1; i <= 33; i++) begin
            tick();
            if (bus.md_start === 1'b1) starts++;
        end
        tests++;
        if (bus.state !== 4'd4 || bus.step !== 3'd0) begin
            fails++;
            $display("FAIL md_wait state=%0d step=%0d exp 4/0",
                     bus.state, bus.step);
        end
        bus.md_done = 1'b1;
        tick();
        bus.md_done = 1'b0;
        tests++;
        if (bus.state !== 4'd3 || bus.step !== 3'd1 || starts !== 1) begin
            fails++;
            $display("FAIL md_resume state=%0d step=%0d starts=%0d exp 3/1/1",
                     bus.state, bus.step, starts);
        end
        tick();
        tests++;
        if (bus.state !== 4'd1 || bus.step !== 3'd0) begin
            fails++;
            $display("FAIL md_ret state=%0d step=%0d exp 1/0",
                     bus.state, bus.step);
        end
    endtask

    task automatic test_divzero();
        to_decode();
        bus.is_muldiv  = 1'b1;
        bus.exec_steps = 3'd2;
        tick();
        clear_in();
        bus.divzero = 1'b1;
        tick();
        bus.divzero = 1'b0;
        tests++;
        if (bus.state !== 4'd5 || bus.md_start !== 1'b0 ||
            bus.exc_code !== 2'd2) begin
            fails++;
            $display("FAIL dz_epc state=%0d mds=%0b code=%0d exp 5/0/2",
                     bus.state, bus.md_start, bus.exc_code);
        end
        tick();
        tests++;
        if (bus.state !== 4'd6 || bus.exc_addr !== 8'd255) begin
            fails++;
            $display("FAIL dz_addr state=%0d addr=%0d exp 6/255",
                     bus.state, bus.exc_addr);
        end
        tick();
        tick();
        tick();
        tests++;
        if (bus.state !== 4'd1) begin
            fails++;
            $display("FAIL dz_ret state=%0d exp 1", bus.state);
        end
    endtask

    task automatic test_timeout(input bit late_done);
        to_decode();
        bus.is_muldiv  = 1'b1;
        bus.exec_steps = 3'd2;
        tick();
        clear_in();
        tick();
        for (int i = 1; i <= 39; i++) tick();
        tests++;
        if (bus.state !== 4'd4) begin
            fails++;
            $display("FAIL to_40th state=%0d exp 4", bus.state);
        end
        if (late_done) begin
            bus.md_done = 1'b1;
            tick();
            bus.md_done = 1'b0;
            tests++;
            if (bus.state !== 4'd3 || bus.step !== 3'd1) begin
                fails++;
                $display("FAIL to_late state=%0d step=%0d exp 3/1",
                         bus.state, bus.step);
            end
            tick();
            tests++;
            if (bus.state !== 4'd1 || bus.exc_code !== 2'd3) begin
                fails++;
                $display("FAIL to_late_ret state=%0d code=%0d exp 1/3",
                         bus.state, bus.exc_code);
            end
        end else begin
            tick();
            tests++;
            if (bus.state !== 4'd5 || bus.exc_code !== 2'd3) begin
                fails++;
                $display("FAIL to_exc state=%0d code=%0d exp 5/3",
                         bus.state, bus.exc_code);
            end
            tick();
            tests++;
            if (bus.exc_addr !== 8'd255 || bus.IorD !== 3'b010) begin
                fails++;
                $display("FAIL to_addr addr=%0d iord=%b exp 255/010",
                         bus.exc_addr, bus.IorD);
            end
            tick();
            tick();
            tick();
            tests++;
            if (bus.state !== 4'd1) begin
                fails++;
                $display("FAIL to_ret state=%0d exp 1", bus.state);
            end
        end
    endtask

    task automatic test_reset_mdwait();
        to_decode();
        bus.is_muldiv  = 1'b1;
        bus.exec_steps = 3'd2;
        tick();
        clear_in();
        tick();
        tick();
        reset = 1'b1;
        tick();
        tests++;
        if (bus.state !== 4'd0 || bus.md_start !== 1'b0 ||
            bus.reset_out !== 1'b1) begin
            fails++;
            $display("FAIL rmd_state state=%0d mds=%0b rout=%0b exp 0/0/1",
                     bus.state, bus.md_start, bus.reset_out);
        end
        tests++;
        if (bus.exc_code !== 2'd0 || wen() !== 6'b0) begin
            fails++;
            $display("FAIL rmd_clear code=%0d wen=%b exp 0/0",
                     bus.exc_code, wen());
        end
        reset = 1'b0;
        tick();
        tests++;
        if (bus.state !== 4'd1 || bus.reset_out !== 1'b0) begin
            fails++;
            $display("FAIL rmd_fetch state=%0d exp 1", bus.state);
        end
    endtask

    task automatic test_priority();
        to_decode();
        bus.invalid_opcode = 1'b1;
        bus.is_break       = 1'b1;
        bus.exec_steps     = 3'd3;
        tick();
        clear_in();
        tests++;
        if (bus.state !== 4'd5 || bus.exc_code !== 2'd0 ||
            bus.halted !== 1'b0) begin
            fails++;
            $display("FAIL prio state=%0d code=%0d halt=%0b exp 5/0/0",
                     bus.state, bus.exc_code, bus.halted);
        end
        tick();
        tests++;
        if (bus.exc_addr !== 8'd253) begin
            fails++;
            $display("FAIL prio_addr addr=%0d exp 253", bus.exc_addr);
        end
        tick();
        tick();
        tick();
        tests++;
        if (bus.state !== 4'd1) begin
            fails++;
            $display("FAIL prio_ret state=%0d exp 1", bus.state);
        end
    endtask

    task automatic test_halt();
        to_decode();
        bus.is_break   = 1'b1;
        bus.exec_steps = 3'd2;
        tick();
        clear_in();
        tests++;
        if (bus.state !== 4'd8 || bus.halted !== 1'b1) begin
            fails++;
            $display("FAIL halt_enter state=%0d halt=%0b exp 8/1",
                     bus.state, bus.halted);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            tests++;
            if (bus.state !== 4'd8 || bus.halted !== 1'b1 ||
                wen() !== 6'b0) begin
                fails++;
                $display("FAIL halt_hold cyc=%0d state=%0d wen=%b exp 8/0",
                         i, bus.state, wen());
            end
        end
        reset = 1'b1;
        tick();
        tests++;
        if (bus.state !== 4'd0 || bus.halted !== 1'b0) begin
            fails++;
            $display("FAIL halt_exit state=%0d halt=%0b exp 0/0",
                     bus.state, bus.halted);
        end
        reset = 1'b0;
        tick();
    endtask

    initial begin
        clear_in();
        reset = 1'b1;
        test_reset();
        test_alu();
        test_max_steps();
        test_overflow();
        test_muldiv();
        test_divzero();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_reset_mdwait();
        test_priority();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
